// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier.
// The operand width is fixed by the eight_bit_adder it is built around.
package mult_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/eight_bit_adder.sv
// Existing 8-bit ripple adder block: sum and carry-out of a + b + cin.
module eight_bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned multiplier, one multiplier bit per cycle,
// reusing eight_bit_adder for the partial-product accumulation.
module shift_add_multiplier
    import mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               last;

    assign addend = q[0] ? m : '0;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    eight_bit_adder u_add (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a;
                        q   <= b;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    // carry-out shifts into acc msb so nothing is lost
                    acc <= {carry, sum[WIDTH-1:1]};
                    q   <= {sum[0], q[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (last)
                        product <= {carry, sum, q[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

endmodule
